// File: rtl/systolic_array_gen.sv
// Output-stationary DIM x DIM signed systolic matrix multiplier, C = A x B.
// Define SYSTOLIC_SAT_EN for saturating accumulators (default: wrap).
module systolic_array_gen #(
    parameter int N     = 32,
    parameter int DIM   = 4,
    parameter int ACC_W = 72,
    parameter int KW    = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [KW-1:0]                          k_len,
    output logic                                   busy,
    output logic                                   done,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DIM*N-1:0]                       a_vec,
    input  logic [DIM*N-1:0]                       b_vec,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [DIM*ACC_W-1:0]                   res_row,
    output logic [(DIM > 2 ? $clog2(DIM) : 1)-1:0] res_idx
);
    localparam int IW = (DIM > 2) ? $clog2(DIM) : 1;
    localparam int FW = $clog2(2 * DIM);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state;
    logic [KW-1:0] k_lat;
    logic [KW-1:0] k_cnt;
    logic [FW-1:0] f_cnt;
    logic [IW-1:0] r_idx;
    logic          beat;
    logic          clr;

    // sk_a[i][s]: skew line for row i, tapped at stage i
    logic [N-1:0] sk_a  [DIM][DIM];
    logic         sk_av [DIM][DIM];
    logic [N-1:0] sk_b  [DIM][DIM];
    logic         sk_bv [DIM][DIM];

    logic [N-1:0] a_r   [DIM][DIM];
    logic         av_r  [DIM][DIM];
    logic [N-1:0] b_r   [DIM][DIM];
    logic         bv_r  [DIM][DIM];

    logic [N-1:0] a_cur  [DIM][DIM];
    logic         av_cur [DIM][DIM];
    logic [N-1:0] b_cur  [DIM][DIM];
    logic         bv_cur [DIM][DIM];

    logic signed [2*N-1:0]  prod    [DIM][DIM];
    logic signed [ACC_W-1:0] ext     [DIM][DIM];
    logic signed [ACC_W-1:0] acc     [DIM][DIM];
    logic signed [ACC_W-1:0] acc_nxt [DIM][DIM];
`ifdef SYSTOLIC_SAT_EN
    logic [ACC_W:0] wide [DIM][DIM];
`endif

    assign beat      = in_valid && (state == S_LOAD);
    assign clr       = start && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign in_ready  = (state == S_LOAD);
    assign res_valid = (state == S_DRAIN);
    assign res_idx   = r_idx;

    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_cur[i][0]  = sk_a[i][i];
            av_cur[i][0] = sk_av[i][i];
            b_cur[0][i]  = sk_b[i][i];
            bv_cur[0][i] = sk_bv[i][i];
        end
        for (int i = 0; i < DIM; i++) begin
            for (int j = 1; j < DIM; j++) begin
                a_cur[i][j]  = a_r[i][j-1];
                av_cur[i][j] = av_r[i][j-1];
                b_cur[j][i]  = b_r[j-1][i];
                bv_cur[j][i] = bv_r[j-1][i];
            end
        end
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                prod[i][j] = (2*N)'($signed(a_cur[i][j])) *
                             (2*N)'($signed(b_cur[i][j]));
                ext[i][j]  = ACC_W'(prod[i][j]);
`ifdef SYSTOLIC_SAT_EN
                wide[i][j] = {acc[i][j][ACC_W-1], acc[i][j]} +
                             {ext[i][j][ACC_W-1], ext[i][j]};
                if (wide[i][j][ACC_W] != wide[i][j][ACC_W-1])
                    acc_nxt[i][j] = wide[i][j][ACC_W] ?
                        {1'b1, {(ACC_W-1){1'b0}}} :
                        {1'b0, {(ACC_W-1){1'b1}}};
                else
                    acc_nxt[i][j] = wide[i][j][ACC_W-1:0];
`else
                acc_nxt[i][j] = acc[i][j] + ext[i][j];
`endif
            end
        end
    end

    always_comb begin
        res_row = '0;
        if (state == S_DRAIN) begin
            for (int j = 0; j < DIM; j++)
                res_row[j*ACC_W +: ACC_W] = acc[r_idx][j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k_lat <= '0;
            k_cnt <= '0;
            f_cnt <= '0;
            r_idx <= '0;
            done  <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    sk_a[i][j]  <= '0;
                    sk_av[i][j] <= 1'b0;
                    sk_b[i][j]  <= '0;
                    sk_bv[i][j] <= 1'b0;
                    a_r[i][j]   <= '0;
                    av_r[i][j]  <= 1'b0;
                    b_r[i][j]   <= '0;
                    bv_r[i][j]  <= 1'b0;
                    acc[i][j]   <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_lat <= k_len;
                        k_cnt <= '0;
                        r_idx <= '0;
                        state <= (k_len != '0) ? S_LOAD : S_DRAIN;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        if (k_cnt == k_lat - KW'(1)) begin
                            f_cnt <= '0;
                            state <= S_FLUSH;
                        end else begin
                            k_cnt <= k_cnt + KW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (f_cnt == FW'(2*DIM-2))
                        state <= S_DRAIN;
                    else
                        f_cnt <= f_cnt + FW'(1);
                end
                default: begin
                    if (res_ready) begin
                        if (r_idx == IW'(DIM-1)) begin
                            r_idx <= '0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
            endcase
            for (int i = 0; i < DIM; i++) begin
                sk_a[i][0]  <= a_vec[i*N +: N];
                sk_av[i][0] <= beat;
                sk_b[i][0]  <= b_vec[i*N +: N];
                sk_bv[i][0] <= beat;
                for (int s = 1; s < DIM; s++) begin
                    sk_a[i][s]  <= sk_a[i][s-1];
                    sk_av[i][s] <= sk_av[i][s-1];
                    sk_b[i][s]  <= sk_b[i][s-1];
                    sk_bv[i][s] <= sk_bv[i][s-1];
                end
                for (int j = 0; j < DIM; j++) begin
                    a_r[i][j]  <= a_cur[i][j];
                    av_r[i][j] <= av_cur[i][j];
                    b_r[i][j]  <= b_cur[i][j];
                    bv_r[i][j] <= bv_cur[i][j];
                    if (clr)
                        acc[i][j] <= '0;
                    else if (av_cur[i][j] && bv_cur[i][j])
                        acc[i][j] <= acc_nxt[i][j];
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_array_gen.sv
// Bench for systolic_array_gen at DIM=2, N=8, ACC_W=16, KW=4.
// Job table plus scoreboard of expected result rows; reset sequences by hand.
module tb_systolic_array_gen;
    localparam int N     = 8;
    localparam int DIM   = 2;
    localparam int ACC_W = 16;
    localparam int KW    = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 busy;
    logic                 done;
    logic                 in_valid;
    logic                 in_ready;
    logic [DIM*N-1:0]     a_vec;
    logic [DIM*N-1:0]     b_vec;
    logic                 res_valid;
    logic                 res_ready;
    logic [DIM*ACC_W-1:0] res_row;
    logic [0:0]           res_idx;

    systolic_array_gen #(.N(N), .DIM(DIM), .ACC_W(ACC_W), .KW(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .a_vec(a_vec), .b_vec(b_vec), .res_valid(res_valid),
        .res_ready(res_ready), .res_row(res_row), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]             k;
        logic                   gap;
        logic [3:0]             bp;
        logic [1:0][3:0][7:0]   a;
        logic [3:0][1:0][7:0]   b;
        logic [1:0][1:0][15:0]  exp;
    } vec_t;

    typedef struct packed {
        logic        idx;
        logic [31:0] row;
    } exp_t;

    vec_t tbl [6];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

`ifdef SYSTOLIC_SAT_EN
    localparam logic [15:0] ALL127 = 16'h7FFF;
    localparam logic [15:0] NEG00  = 16'h7FFF;
`else
    localparam logic [15:0] ALL127 = 16'hFC04;
    localparam logic [15:0] NEG00  = 16'h8000;
`endif

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_job(input vec_t v);
        int   beat;
        int   ph;
        int   cyc;
        int   fl;
        int   rows;
        int   stall;
        exp_t e;
        start = 1'b1;
        k_len = v.k;
        for (int r = 0; r < 2; r++) begin
            e.idx = r[0];
            e.row = v.exp[r];
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_width", done, 0);
        chk("busy_after_start", busy, 1);
        beat = 0;
        ph   = 0;
        cyc  = 0;
        while (beat < int'(v.k) && cyc < 100) begin
            in_valid = !(v.gap && ph[0]);
            ph++;
            for (int r = 0; r < 2; r++) begin
                a_vec[r*8 +: 8] = v.a[r][beat];
                b_vec[r*8 +: 8] = v.b[beat][r];
            end
            #1;
            if (in_valid && in_ready) beat++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        a_vec    = 16'($urandom);
        b_vec    = 16'($urandom);
        chk("beats_accepted", beat, v.k);
        fl = 0;
        while (!res_valid && fl < 50) begin
            fl++;
            @(negedge clk);
        end
        chk("flush_len", fl, (v.k != 0) ? 2*DIM-1 : 0);
        rows  = 0;
        stall = 0;
        cyc   = 0;
        while (rows < 2 && cyc < 100) begin
            res_ready = (stall >= int'(v.bp));
            if (!res_ready) stall++;
            if (res_valid && sb.size() > 0) begin
                chk("res_row", res_row, sb[0].row);
                chk("res_idx", res_idx, sb[0].idx);
                if (res_ready) begin
                    void'(sb.pop_front());
                    rows++;
                end
            end else begin
                chk("res_valid_drain", res_valid, 1);
            end
            chk("done_in_drain", done, 0);
            @(negedge clk);
            cyc++;
        end
        chk("rows_drained", rows, 2);
        chk("done_pulse", done, 1);
        chk("idle_after_job", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        a_vec     = '0;
        b_vec     = '0;
        res_ready = 1'b0;

        for (int i = 0; i < 6; i++) tbl[i] = '0;
        tbl[0].k = 2;
        tbl[0].a[0][0] = 1;  tbl[0].a[1][1] = 1;
        tbl[0].b[0][0] = 1;  tbl[0].b[0][1] = 2;
        tbl[0].b[1][0] = 3;  tbl[0].b[1][1] = 4;
        tbl[0].exp[0][0] = 1; tbl[0].exp[0][1] = 2;
        tbl[0].exp[1][0] = 3; tbl[0].exp[1][1] = 4;

        tbl[1].k = 3; tbl[1].gap = 1'b1;
        tbl[1].a[0][0] = 1;  tbl[1].a[0][1] = 8'hFE; tbl[1].a[0][2] = 3;
        tbl[1].a[1][0] = 4;  tbl[1].a[1][1] = 5;     tbl[1].a[1][2] = 8'hFA;
        tbl[1].b[0][0] = 7;  tbl[1].b[0][1] = 8;
        tbl[1].b[1][0] = 9;  tbl[1].b[1][1] = 10;
        tbl[1].b[2][0] = 11; tbl[1].b[2][1] = 12;
        tbl[1].exp[0][0] = 22; tbl[1].exp[0][1] = 24;
        tbl[1].exp[1][0] = 7;  tbl[1].exp[1][1] = 10;

        tbl[2].k = 1; tbl[2].bp = 5;
        tbl[2].a[0][0] = 2;  tbl[2].a[1][0] = 8'hFD;
        tbl[2].b[0][0] = 5;  tbl[2].b[0][1] = 6;
        tbl[2].exp[0][0] = 10;      tbl[2].exp[0][1] = 12;
        tbl[2].exp[1][0] = 16'hFFF1; tbl[2].exp[1][1] = 16'hFFEE;

        tbl[3].k = 4;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                tbl[3].a[r][k] = 8'd127;
                tbl[3].b[k][r] = 8'd127;
            end
            for (int c = 0; c < 2; c++) tbl[3].exp[r][c] = ALL127;
        end

        tbl[4].k = 0;

        tbl[5].k = 2; tbl[5].gap = 1'b1; tbl[5].bp = 2;
        tbl[5].a[0][0] = 8'h80; tbl[5].a[0][1] = 8'h80;
        tbl[5].a[1][0] = 8'd127; tbl[5].a[1][1] = 8'h80;
        tbl[5].b[0][0] = 8'h80; tbl[5].b[0][1] = 8'd127;
        tbl[5].b[1][0] = 8'h80; tbl[5].b[1][1] = 8'h80;
        tbl[5].exp[0][0] = NEG00;  tbl[5].exp[0][1] = 16'd128;
        tbl[5].exp[1][0] = 16'd128; tbl[5].exp[1][1] = 16'd32513;

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_row", res_row, 0);
        chk("rst_res_idx", res_idx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_job(tbl[i]);

        start = 1'b1;
        k_len = 3;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        a_vec    = 16'h0305;
        b_vec    = 16'h0407;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midload_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_res_row", res_row, 0);
        chk("arst_res_idx", res_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_idle", busy, 0);
        end
        run_job(tbl[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
